pushbutton_conditioner: RTL and testbench
=========================================

Name: pushbutton_conditioner

Overview:
Front-end conditioner for the active-low Pushn key before it reaches the reaction timer state machine. It synchronises and debounces the key, then emits single-cycle Press and Release pulses on Clock. Those pulses replace direct edge-triggering on the raw button. It also reports a held level and a one-shot long-press event, so a long hold can be used as a software "clear best time" gesture.

Parameters:
SYNC_STAGES, 2, number of synchroniser flops on Pushn (legal range 2 to 4)
DEBOUNCE_CYCLES, 500000, consecutive stable synced samples required to accept a level change (10 ms at 50 MHz); minimum 2
LONG_CYCLES, 50000000, Clock cycles a confirmed press must persist before LongPress fires (1 s at 50 MHz); must be greater than DEBOUNCE_CYCLES
CNT_W, 26, width of the debounce and hold counters; must satisfy 2^CNT_W > LONG_CYCLES

Ports:
Clock  input  1  system clock; every flop in the block is clocked on its rising edge
Reset  input  1  synchronous, active-high reset
Pushn  input  1  raw, asynchronous, bouncing key; 0 = pressed
Press  output  1  one-cycle pulse when a press is confirmed
Release  output  1  one-cycle pulse when a release is confirmed after a confirmed press
Level  output  1  debounced key state; 1 = pressed
LongPress  output  1  one-cycle pulse when a confirmed press reaches LONG_CYCLES
Held  output  1  1 from the LongPress pulse until the release is confirmed

Behaviour:
- Clocking and reset: one clock domain, Clock. Reset is synchronous and active-high.
- Reset values:
  - Press, Release, LongPress, Level and Held all 0.
  - All synchroniser flops 1 (released).
  - Both counters 0.
  - State ARM.
- Synchroniser: Pushn passes through SYNC_STAGES flops. The last stage is sample s, and all decisions use s only.
- ARM state (entered only from reset):
  - Counts consecutive s==1 samples; any s==0 clears the count.
  - Goes to IDLE when the count reaches DEBOUNCE_CYCLES.
  - Emits no pulses, so a key held through reset never produces a Press until it has been released and pressed again.
- IDLE: on s==0, go to PRESS_WAIT with count=1.
- PRESS_WAIT:
  - If s==0, increment the count. When the count reaches DEBOUNCE_CYCLES, go to PRESSED, set Level=1 and pulse Press.
  - If s==1, go back to IDLE and clear the count; no pulse is emitted.
- PRESSED:
  - The hold counter increments every cycle from entry and saturates at LONG_CYCLES.
  - When it first equals LONG_CYCLES, pulse LongPress and set Held=1. This fires at most once per press.
  - On s==1, go to RELEASE_WAIT with count=1. The hold counter pauses; it does not clear.
- RELEASE_WAIT:
  - If s==1, increment the count. When the count reaches DEBOUNCE_CYCLES, go to IDLE, set Level=0 and Held=0, clear the hold counter and pulse Release.
  - If s==0 (bounce), return to PRESSED and clear the debounce count. The hold counter resumes and Level stays 1.
- Latency: with Pushn stable low from before rising edge 0, Press is high for exactly the cycle following edge SYNC_STAGES+DEBOUNCE_CYCLES-1, and Level rises on that same edge. Release has the same latency relative to a stable high.
- Pulse rules:
  - Every pulse output lasts exactly one cycle.
  - Press and Release are never high together.
  - If LONG_CYCLES would be reached on the same cycle as Release, Release wins and LongPress is suppressed.
- Glitches: a bounce shorter than DEBOUNCE_CYCLES samples never changes Level or produces any pulse.
- Reset mid-operation: Reset at any state forces the reset values on the next edge. No Release is emitted for a press that was interrupted by Reset.
- Outputs: all outputs are registered; no combinational path from Pushn to any output.

Test Plan:
Bench parameters for all scenarios: SYNC_STAGES=2, DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
- Reset with Pushn=1 for 6 cycles, then drive Pushn=0 from edge 0 and hold it -> Press high only in the cycle after edge 5, Level=1 from edge 5, Release=0.
- After the state is IDLE, apply Pushn low pulses of 1, 2 and 3 cycles separated by 5 high cycles -> Press never asserts and Level stays 0.
- Confirmed press, then release with 2 bounces (high 2 cycles, low 1, then high stable) -> exactly one Release, 4 stable-high samples after the last bounce, and no second Press.
- Hold a confirmed press for 30 cycles -> LongPress pulses once, 20 cycles after Press, Held=1 until the cycle Release pulses, then Held=0.
- Hold Pushn=0 through Reset and for 40 cycles after -> no Press. Then release for 6 cycles and press again -> Press fires with the standard latency.
- Assert Reset for 1 cycle during PRESSED with a partial hold count -> all outputs 0 next cycle, no Release, state ARM.

Source files
------------

// File: rtl/pushbutton_conditioner.sv
// Key front end for the reaction timer: synchronises and debounces the active-low
// Pushn key, then produces Press/Release/LongPress pulses plus debounced Level and Held.
module pushbutton_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000,
    parameter int CNT_W           = 26
) (
    input  logic Clock,
    input  logic Reset,
    input  logic Pushn,
    output logic Press,
    output logic Release,
    output logic Level,
    output logic LongPress,
    output logic Held
);

    typedef enum logic [2:0] {
        ARM,
        IDLE,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYCLES);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync_q;
    logic [CNT_W-1:0]       deb_cnt;
    logic [CNT_W-1:0]       hold_cnt;
    logic                   s;

    // Synchroniser resets to "released" so reset never looks like a key edge.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], Pushn};
        end
    end

    assign s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= ARM;
            deb_cnt   <= '0;
            hold_cnt  <= '0;
            Press     <= 1'b0;
            Release   <= 1'b0;
            LongPress <= 1'b0;
            Level     <= 1'b0;
            Held      <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low every cycle; the states below only raise them.
            Press     <= 1'b0;
            Release   <= 1'b0;
            LongPress <= 1'b0;

            case (state)
                // A key held through reset must be seen released before it can press.
                ARM: begin
                    if (!s) begin
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_ONE;
                    end
                end

                IDLE: begin
                    if (!s) begin
                        state   <= PRESS_WAIT;
                        deb_cnt <= CNT_ONE;
                    end
                end

                PRESS_WAIT: begin
                    if (s) begin
                        state   <= IDLE;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state    <= PRESSED;
                        deb_cnt  <= '0;
                        hold_cnt <= '0;
                        Level    <= 1'b1;
                        Press    <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_ONE;
                    end
                end

                // Hold counter saturates at LONG_CYCLES, so LongPress fires once per press.
                PRESSED: begin
                    if (hold_cnt != LONG_MAX) begin
                        hold_cnt <= hold_cnt + CNT_ONE;
                        if (hold_cnt == LONG_LAST) begin
                            LongPress <= 1'b1;
                            Held      <= 1'b1;
                        end
                    end
                    if (s) begin
                        state   <= RELEASE_WAIT;
                        deb_cnt <= CNT_ONE;
                    end
                end

                RELEASE_WAIT: begin
                    if (!s) begin
                        state   <= PRESSED;
                        deb_cnt <= '0;
                    end else if (deb_cnt == DEB_LAST) begin
                        state    <= IDLE;
                        deb_cnt  <= '0;
                        hold_cnt <= '0;
                        Level    <= 1'b0;
                        Held     <= 1'b0;
                        Release  <= 1'b1;
                    end else begin
                        deb_cnt <= deb_cnt + CNT_ONE;
                    end
                end

                default: begin
                    state   <= ARM;
                    deb_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pushbutton_conditioner.sv
// Directed bench for pushbutton_conditioner with SYNC_STAGES=2, DEBOUNCE_CYCLES=4,
// LONG_CYCLES=20; step index i means "outputs observed just after that rising edge".
module tb_pushbutton_conditioner;

    logic Clock = 1'b0;
    logic Reset;
    logic Pushn;
    logic Press;
    logic Release;
    logic Level;
    logic LongPress;
    logic Held;

    int n_cmp     = 0;
    int n_fail    = 0;
    int n_press   = 0;
    int n_release = 0;
    int n_long    = 0;
    int p0;
    int r0;
    int l0;

    pushbutton_conditioner #(
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20),
        .CNT_W          (8)
    ) dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Pushn    (Pushn),
        .Press    (Press),
        .Release  (Release),
        .Level    (Level),
        .LongPress(LongPress),
        .Held     (Held)
    );

    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive Pushn, take one rising edge, then observe 1 time unit later.
    task automatic step(input logic p);
        Pushn = p;
        @(posedge Clock);
        #1;
        if (Press)     n_press++;
        if (Release)   n_release++;
        if (LongPress) n_long++;
        check("press_release_excl", {31'd0, Press & Release}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_press"},   {31'd0, Press},     32'd0);
        check({tag, "_release"}, {31'd0, Release},   32'd0);
        check({tag, "_level"},   {31'd0, Level},     32'd0);
        check({tag, "_long"},    {31'd0, LongPress}, 32'd0);
        check({tag, "_held"},    {31'd0, Held},      32'd0);
    endtask

    initial begin
        // Reset state
        Reset = 1'b1;
        step(1'b1);
        step(1'b1);
        check_all_zero("rst");
        Reset = 1'b0;
        repeat (6) step(1'b1);

        // Scenario 1: clean press, Press after edge 5
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            check("s1_press",   {31'd0, Press},   32'(i == 5));
            check("s1_level",   {31'd0, Level},   32'(i >= 5));
            check("s1_release", {31'd0, Release}, 32'd0);
        end
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            check("s1_rel_pulse", {31'd0, Release}, 32'(i == 5));
            check("s1_rel_level", {31'd0, Level},   32'(i < 5));
        end
        repeat (4) step(1'b1);

        // Scenario 2: short glitches of 1, 2, 3 low cycles
        p0 = n_press;
        for (int w = 1; w <= 3; w++) begin
            repeat (w) begin
                step(1'b0);
                check("s2_level_low", {31'd0, Level}, 32'd0);
            end
            repeat (5) begin
                step(1'b1);
                check("s2_level_high", {31'd0, Level}, 32'd0);
            end
        end
        check("s2_press_count", n_press, p0);

        // Scenario 3: confirmed press then a bouncy release
        p0 = n_press;
        r0 = n_release;
        l0 = n_long;
        repeat (10) step(1'b0);
        check("s3_press_count", n_press, p0 + 1);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        step(1'b1);
        step(1'b1);
        step(1'b0);
        check("s3_level_bounce", {31'd0, Level}, 32'd1);
        check("s3_no_early_release", n_release, r0);
        for (int i = 0; i < 10; i++) begin
            step(1'b1);
            check("s3_release", {31'd0, Release}, 32'(i == 5));
        end
        check("s3_release_count", n_release, r0 + 1);
        check("s3_press_once", n_press, p0 + 1);
        check("s3_no_long", n_long, l0);
        repeat (4) step(1'b1);

        // Scenario 4: long hold, LongPress 20 cycles after Press
        l0 = n_long;
        for (int i = 0; i < 36; i++) begin
            step(1'b0);
            check("s4_press", {31'd0, Press},     32'(i == 5));
            check("s4_level", {31'd0, Level},     32'(i >= 5));
            check("s4_long",  {31'd0, LongPress}, 32'(i == 25));
            check("s4_held",  {31'd0, Held},      32'(i >= 25));
        end
        check("s4_long_count", n_long, l0 + 1);
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            check("s4_release",  {31'd0, Release}, 32'(i == 5));
            check("s4_held_rel", {31'd0, Held},    32'(i < 5));
        end
        repeat (4) step(1'b1);

        // Scenario 5: key held through reset gives no Press until re-pressed
        Reset = 1'b1;
        step(1'b0);
        step(1'b0);
        Reset = 1'b0;
        p0 = n_press;
        for (int i = 0; i < 40; i++) begin
            step(1'b0);
            check("s5_level_held", {31'd0, Level}, 32'd0);
        end
        check("s5_no_press", n_press, p0);
        repeat (6) step(1'b1);
        for (int i = 0; i < 8; i++) begin
            step(1'b0);
            check("s5_press", {31'd0, Press}, 32'(i == 5));
            check("s5_level", {31'd0, Level}, 32'(i >= 5));
        end

        // Scenario 6: reset during PRESSED with partial hold count
        r0 = n_release;
        p0 = n_press;
        Reset = 1'b1;
        step(1'b0);
        check_all_zero("s6_rst");
        Reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step(1'b0);
            check("s6_level", {31'd0, Level}, 32'd0);
        end
        check("s6_no_release", n_release, r0);
        check("s6_arm_no_press", n_press, p0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
